// File: rtl/eq_ctrl_pkg.sv
// Shared types and default constants for the EQ gain sequencer.
package eq_ctrl_pkg;

  localparam int unsigned DEF_LEVEL_W      = 5;
  localparam int          DEF_LEVEL_MIN    = -12;
  localparam int          DEF_LEVEL_MAX    = 12;
  localparam int unsigned DEF_DEBOUNCE_CYC = 500000;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CAPTURE = 2'd1,
    RAMP    = 2'd2,
    PUSH    = 2'd3
  } eq_state_e;

endpackage

// File: rtl/set_debounce.sv
// Button conditioning: 2-flop synchronizer, counting debouncer and rising-edge pulse.
module set_debounce
  import eq_ctrl_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYC = DEF_DEBOUNCE_CYC
) (
  input  logic clk,
  input  logic rst_n,
  input  logic set,
  output logic set_evt
);

  localparam int unsigned CNT_W = (DEBOUNCE_CYC > 1) ? $clog2(DEBOUNCE_CYC) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYC - 1);

  logic [1:0]       sync_q;
  logic             db_q;
  logic [CNT_W-1:0] cnt_q;

  // Synchronize, count consecutive samples differing from the debounced level, flip on the last one.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q  <= 2'b00;
      db_q    <= 1'b0;
      cnt_q   <= '0;
      set_evt <= 1'b0;
    end else begin
      sync_q  <= {sync_q[0], set};
      set_evt <= 1'b0;
      if (sync_q[1] == db_q) begin
        cnt_q <= '0;
      end else if (cnt_q == CNT_LAST) begin
        cnt_q   <= '0;
        db_q    <= sync_q[1];
        set_evt <= sync_q[1];
      end else begin
        cnt_q <= cnt_q + CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/eq_gain_sequencer.sv
// Button-triggered capture of three band levels and hand-off of gains to the equalizer.
// Optional feature macro EQ_GAIN_RAMP_EN: when defined, gains walk one step per
// sample_tick toward the captured targets with a handshake per step; otherwise
// the clamped targets are pushed in a single transfer.
module eq_gain_sequencer
  import eq_ctrl_pkg::*;
#(
  parameter int unsigned LEVEL_W      = DEF_LEVEL_W,
  parameter int          LEVEL_MIN    = DEF_LEVEL_MIN,
  parameter int          LEVEL_MAX    = DEF_LEVEL_MAX,
  parameter int unsigned DEBOUNCE_CYC = DEF_DEBOUNCE_CYC
) (
  input  logic                      CLOCK_50,
  input  logic                      reset,
  input  logic                      set,
  input  logic signed [LEVEL_W-1:0] bass_level,
  input  logic signed [LEVEL_W-1:0] mid_level,
  input  logic signed [LEVEL_W-1:0] treble_level,
  input  logic                      sample_tick,
  output logic signed [LEVEL_W-1:0] bass_gain,
  output logic signed [LEVEL_W-1:0] mid_gain,
  output logic signed [LEVEL_W-1:0] treble_gain,
  output logic                      gain_valid,
  input  logic                      gain_ready,
  output logic                      busy
);

  localparam int unsigned NUM_BANDS = 3;

  typedef logic signed [LEVEL_W-1:0] level_t;

  localparam level_t MIN_L = LEVEL_W'(LEVEL_MIN);
  localparam level_t MAX_L = LEVEL_W'(LEVEL_MAX);

  eq_state_e state_q, state_n;
  logic      pending_q, pending_n;
  logic      set_evt;
  level_t    level_c  [NUM_BANDS];
  level_t    gain_q   [NUM_BANDS];
  level_t    gain_n   [NUM_BANDS];
  level_t    target_q [NUM_BANDS];
  level_t    target_n [NUM_BANDS];

  function automatic level_t clamp_level(input level_t v);
    level_t r;
    r = v;
    if (v < MIN_L)      r = MIN_L;
    else if (v > MAX_L) r = MAX_L;
    return r;
  endfunction

  set_debounce #(
    .DEBOUNCE_CYC (DEBOUNCE_CYC)
  ) u_set_debounce (
    .clk     (CLOCK_50),
    .rst_n   (reset),
    .set     (set),
    .set_evt (set_evt)
  );

  assign level_c[0] = bass_level;
  assign level_c[1] = mid_level;
  assign level_c[2] = treble_level;

  assign bass_gain   = gain_q[0];
  assign mid_gain    = gain_q[1];
  assign treble_gain = gain_q[2];

`ifdef EQ_GAIN_RAMP_EN
  localparam level_t ONE_L = LEVEL_W'(1);

  logic at_target_c;

  // All bands already sit on their targets.
  always_comb begin
    at_target_c = 1'b1;
    for (int unsigned i = 0; i < NUM_BANDS; i++) begin
      if (gain_q[i] != target_q[i]) at_target_c = 1'b0;
    end
  end
`else
  logic unused_tick;
  assign unused_tick = sample_tick;
`endif

  // Next-state, pending flag, targets and gains.
  always_comb begin
    state_n   = state_q;
    pending_n = pending_q;
    gain_n    = gain_q;
    target_n  = target_q;
    if (set_evt) pending_n = 1'b1;
    case (state_q)
      IDLE: begin
        if (set_evt || pending_q) begin
          state_n   = CAPTURE;
          pending_n = 1'b0;
        end
      end
      CAPTURE: begin
        for (int unsigned i = 0; i < NUM_BANDS; i++) begin
          target_n[i] = clamp_level(level_c[i]);
`ifndef EQ_GAIN_RAMP_EN
          gain_n[i] = clamp_level(level_c[i]);
`endif
        end
`ifdef EQ_GAIN_RAMP_EN
        state_n = RAMP;
`else
        state_n = PUSH;
`endif
      end
      RAMP: begin
`ifdef EQ_GAIN_RAMP_EN
        if (at_target_c) begin
          state_n = IDLE;
        end else if (sample_tick) begin
          for (int unsigned i = 0; i < NUM_BANDS; i++) begin
            if (gain_q[i] < target_q[i])      gain_n[i] = gain_q[i] + ONE_L;
            else if (gain_q[i] > target_q[i]) gain_n[i] = gain_q[i] - ONE_L;
          end
          state_n = PUSH;
        end
`else
        state_n = IDLE;
`endif
      end
      PUSH: begin
        if (gain_ready) begin
`ifdef EQ_GAIN_RAMP_EN
          state_n = RAMP;
`else
          state_n = IDLE;
`endif
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // State, data and registered status outputs.
  always_ff @(posedge CLOCK_50 or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      pending_q  <= 1'b0;
      gain_valid <= 1'b0;
      busy       <= 1'b0;
      for (int unsigned i = 0; i < NUM_BANDS; i++) begin
        gain_q[i]   <= '0;
        target_q[i] <= '0;
      end
    end else begin
      state_q    <= state_n;
      pending_q  <= pending_n;
      gain_valid <= (state_n == PUSH);
      busy       <= (state_n != IDLE);
      gain_q     <= gain_n;
      target_q   <= target_n;
    end
  end

endmodule

// File: tb/tb_eq_gain_sequencer.sv
// Self-checking bench for eq_gain_sequencer against a transfer-level model.
module tb_eq_gain_sequencer;

  localparam int unsigned W     = 5;
  localparam int unsigned DB    = 4;
  localparam int          LMIN  = -12;
  localparam int          LMAX  = 12;
  localparam int          BOUND = 5000;

  logic                CLOCK_50    = 1'b0;
  logic                reset       = 1'b1;
  logic                set         = 1'b0;
  logic                sample_tick = 1'b0;
  logic                gain_ready  = 1'b1;
  logic signed [W-1:0] bass_level  = '0;
  logic signed [W-1:0] mid_level   = '0;
  logic signed [W-1:0] treble_level = '0;
  logic signed [W-1:0] bass_gain, mid_gain, treble_gain;
  logic                gain_valid, busy;

  eq_gain_sequencer #(
    .LEVEL_W      (W),
    .LEVEL_MIN    (LMIN),
    .LEVEL_MAX    (LMAX),
    .DEBOUNCE_CYC (DB)
  ) dut (
    .CLOCK_50     (CLOCK_50),
    .reset        (reset),
    .set          (set),
    .bass_level   (bass_level),
    .mid_level    (mid_level),
    .treble_level (treble_level),
    .sample_tick  (sample_tick),
    .bass_gain    (bass_gain),
    .mid_gain     (mid_gain),
    .treble_gain  (treble_gain),
    .gain_valid   (gain_valid),
    .gain_ready   (gain_ready),
    .busy         (busy)
  );

  always #10 CLOCK_50 = ~CLOCK_50;

  typedef struct { int b; int m; int t; } xfer_t;

  xfer_t obs_q[$];
  xfer_t exp_q[$];
  int    n_tests = 0;
  int    n_fail  = 0;
  int    g_b = 0, g_m = 0, g_t = 0;
  bit    mon_en = 1'b0;
  int    ready_mode = 0;
  logic  ready_force = 1'b1;
  int    tick_cnt = 0;

  // Audio sample pulse every 10 clocks.
  always @(posedge CLOCK_50) begin
    #1;
    tick_cnt    = (tick_cnt == 9) ? 0 : tick_cnt + 1;
    sample_tick = (tick_cnt == 0);
  end

  // Equalizer ready: forced level or random back-pressure.
  always @(posedge CLOCK_50) begin
    #1;
    if (ready_mode == 1) gain_ready = 1'($urandom_range(0, 1));
    else                 gain_ready = ready_force;
  end

  logic signed [W-1:0] pb, pm, pt;
  logic pv, pr;
  bit   have_prev = 1'b0;

  // Record transfers and check that a stalled update holds.
  always @(negedge CLOCK_50) begin
    if (!mon_en) begin
      have_prev = 1'b0;
    end else begin
      if (have_prev && pv === 1'b1 && pr !== 1'b1) begin
        n_tests++;
        assert (gain_valid === 1'b1 && bass_gain === pb && mid_gain === pm && treble_gain === pt)
        else begin
          n_fail++;
          $error("FAIL hold: observed valid=%b gains=(%0d,%0d,%0d) expected valid=1 gains=(%0d,%0d,%0d)",
                 gain_valid, bass_gain, mid_gain, treble_gain, pb, pm, pt);
        end
      end
      if (gain_valid === 1'b1 && gain_ready === 1'b1)
        obs_q.push_back('{int'(bass_gain), int'(mid_gain), int'(treble_gain)});
      pv = gain_valid; pr = gain_ready;
      pb = bass_gain; pm = mid_gain; pt = treble_gain;
      have_prev = 1'b1;
    end
  end

  task automatic chk(input string tag, input logic signed [31:0] got, input logic signed [31:0] exp);
    n_tests++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic cycles(input int n);
    repeat (n) begin
      @(posedge CLOCK_50);
      #1;
    end
  endtask

  function automatic int clampi(input int v);
    return (v < LMIN) ? LMIN : ((v > LMAX) ? LMAX : v);
  endfunction

  function automatic int step_to(input int g, input int t);
    return (g < t) ? g + 1 : ((g > t) ? g - 1 : g);
  endfunction

  // Expected transfers for one capture of the given raw levels.
  task automatic model_capture(input int lb, input int lm, input int lt);
    int cb, cm, ct;
    cb = clampi(lb); cm = clampi(lm); ct = clampi(lt);
`ifdef EQ_GAIN_RAMP_EN
    while (g_b != cb || g_m != cm || g_t != ct) begin
      g_b = step_to(g_b, cb); g_m = step_to(g_m, cm); g_t = step_to(g_t, ct);
      exp_q.push_back('{g_b, g_m, g_t});
    end
`else
    g_b = cb; g_m = cm; g_t = ct;
    exp_q.push_back('{g_b, g_m, g_t});
`endif
  endtask

  task automatic chk_xfers(input string tag);
    chk({tag, " count"}, obs_q.size(), exp_q.size());
    for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
      chk($sformatf("%s xfer%0d bass", tag, i),   obs_q[i].b, exp_q[i].b);
      chk($sformatf("%s xfer%0d mid", tag, i),    obs_q[i].m, exp_q[i].m);
      chk($sformatf("%s xfer%0d treble", tag, i), obs_q[i].t, exp_q[i].t);
    end
    obs_q.delete();
    exp_q.delete();
  endtask

  task automatic set_levels(input int lb, input int lm, input int lt);
    bass_level   = W'(lb);
    mid_level    = W'(lm);
    treble_level = W'(lt);
  endtask

  task automatic press();
    set = 1'b1;
    cycles(12);
    set = 1'b0;
    cycles(12);
  endtask

  // Wait until busy has been low for several consecutive cycles.
  task automatic wait_idle(input string tag);
    int n, quiet;
    n = 0; quiet = 0;
    while (quiet < 4 && n < BOUND) begin
      cycles(1);
      quiet = (busy === 1'b0) ? quiet + 1 : 0;
      n++;
    end
    chk({tag, " busy settles"}, 32'(busy), 0);
  endtask

  task automatic wait_valid(input string tag);
    int n;
    n = 0;
    while (gain_valid !== 1'b1 && n < BOUND) begin
      cycles(1);
      n++;
    end
    chk({tag, " valid rises"}, 32'(gain_valid), 1);
  endtask

  initial begin
    int busy_seen;
    logic signed [W-1:0] hb, hm, ht;

    // Asynchronous reset state.
    #3 reset = 1'b0;
    #1;
    chk("reset bass", bass_gain, 0);
    chk("reset mid", mid_gain, 0);
    chk("reset treble", treble_gain, 0);
    chk("reset valid", 32'(gain_valid), 0);
    chk("reset busy", 32'(busy), 0);
    cycles(3);
    reset = 1'b1;
    mon_en = 1'b1;
    cycles(2);

    // Basic capture.
    set_levels(3, -2, 0);
    press();
    wait_idle("basic");
    model_capture(3, -2, 0);
    chk_xfers("basic");

    // Clamp boundaries.
    set_levels(15, -16, 12);
    press();
    wait_idle("clamp_hi");
    model_capture(15, -16, 12);
    chk_xfers("clamp_hi");

    set_levels(-12, 11, -13);
    press();
    wait_idle("clamp_lo");
    model_capture(-12, 11, -13);
    chk_xfers("clamp_lo");

    // Random levels, alternating back-pressure.
    for (int it = 0; it < 8; it++) begin
      ready_mode = it % 2;
      bass_level   = W'($urandom_range(0, 31));
      mid_level    = W'($urandom_range(0, 31));
      treble_level = W'($urandom_range(0, 31));
      press();
      wait_idle($sformatf("rand%0d", it));
      model_capture(int'(bass_level), int'(mid_level), int'(treble_level));
      chk_xfers($sformatf("rand%0d", it));
    end
    ready_mode = 0;
    ready_force = 1'b1;
    cycles(2);

    // Stalled handshake holds the update through ticks.
    ready_force = 1'b0;
    set_levels((g_b == 7) ? -7 : 7, (g_m == 7) ? -7 : 7, (g_t == 7) ? -7 : 7);
    press();
    wait_valid("hold");
    model_capture(int'(bass_level), int'(mid_level), int'(treble_level));
    hb = bass_gain; hm = mid_gain; ht = treble_gain;
    cycles(50);
    chk("hold valid", 32'(gain_valid), 1);
    chk("hold bass", bass_gain, exp_q[0].b);
    chk("hold mid", mid_gain, exp_q[0].m);
    chk("hold treble", treble_gain, exp_q[0].t);
    chk("hold bass stable", bass_gain, hb);
    chk("hold obs empty", obs_q.size(), 0);
    ready_force = 1'b1;
    wait_idle("hold");
    chk_xfers("hold");

    // Second press while busy is remembered and re-captured.
    ready_force = 1'b0;
    set_levels(3, -2, 0);
    press();
    wait_valid("pend");
    set_levels(-4, 0, 0);
    press();
    cycles(20);
    ready_force = 1'b1;
    wait_idle("pend");
    model_capture(3, -2, 0);
    model_capture(-4, 0, 0);
    chk_xfers("pend");

    // Short glitch on set is filtered.
    busy_seen = 0;
    set = 1'b1;
    cycles(2);
    set = 1'b0;
    for (int i = 0; i < 30; i++) begin
      cycles(1);
      if (busy !== 1'b0) busy_seen++;
    end
    chk("glitch busy", busy_seen, 0);
    chk("glitch xfers", obs_q.size(), 0);

    // Reset in the middle of a pending update aborts it.
    ready_force = 1'b0;
    set_levels(9, -9, 9);
    press();
    wait_valid("rst");
    chk("rst no xfer", obs_q.size(), 0);
    mon_en = 1'b0;
    @(negedge CLOCK_50);
    #3 reset = 1'b0;
    #1;
    chk("rst bass", bass_gain, 0);
    chk("rst mid", mid_gain, 0);
    chk("rst treble", treble_gain, 0);
    chk("rst valid", 32'(gain_valid), 0);
    chk("rst busy", 32'(busy), 0);
    cycles(3);
    reset = 1'b1;
    obs_q.delete();
    g_b = 0; g_m = 0; g_t = 0;
    ready_force = 1'b1;
    cycles(2);
    mon_en = 1'b1;

    // Capture after reset starts from zero gains.
    set_levels(5, 5, 5);
    press();
    wait_idle("post_rst");
    model_capture(5, 5, 5);
    chk_xfers("post_rst");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/eq_gain_sequencer.md
EQ_GAIN_SEQUENCER -- requirements
Module: eq_gain_sequencer

Interface
REQ-001 The block SHALL have parameter LEVEL_W, default 5: signed width of band levels and gains.
REQ-002 The block SHALL have parameter LEVEL_MIN, default -12: lower clamp for targets.
REQ-003 The block SHALL have parameter LEVEL_MAX, default 12: upper clamp for targets.
REQ-004 The block SHALL have parameter DEBOUNCE_CYC, default 500000: stable cycles required on set, which is 10 ms at 50 MHz.
REQ-005 The block SHALL have port CLOCK_50  in  1: the single clock; all logic sits in this domain.
REQ-006 The block SHALL have port reset  in  1: asynchronous, active-low reset.
REQ-007 The block SHALL have port set  in  1: raw asynchronous button; active-high press.
REQ-008 The block SHALL have ports bass_level, mid_level, treble_level  in  LEVEL_W each: signed requested levels, sampled only at capture.
REQ-009 The block SHALL have port sample_tick  in  1: one-cycle pulse per audio sample; it paces ramp steps.
REQ-010 The block SHALL have ports bass_gain, mid_gain, treble_gain  out  LEVEL_W each: signed current gains toward the equalizer.
REQ-011 The block SHALL have port gain_valid  out  1: gains hold a new update.
REQ-012 The block SHALL have port gain_ready  in  1: the equalizer accepts the update.
REQ-013 The block SHALL have port busy  out  1: high in any state other than IDLE.

Function
REQ-014 set SHALL pass through a 2-flop synchronizer, then a debouncer; the debounced level changes only after DEBOUNCE_CYC consecutive equal synchronized samples.
REQ-015 A 0->1 transition of the debounced level SHALL form a one-cycle set_evt.
REQ-016 The FSM SHALL have states IDLE, CAPTURE, RAMP and PUSH.
REQ-017 In IDLE, on set_evt or pending=1, the FSM SHALL go to CAPTURE and clear pending.
REQ-018 In CAPTURE, which lasts one cycle, each level SHALL be clamped to [LEVEL_MIN, LEVEL_MAX] and stored as its band target; the FSM then goes to RAMP.
REQ-019 In RAMP, on sample_tick, each band's gain SHALL move by +1 or -1 toward its target independently; a band already at target is unchanged.
REQ-020 In RAMP, after a step that changed any band, the FSM SHALL go to PUSH on the next cycle; if every band already equals its target, it SHALL go to IDLE without asserting gain_valid.
REQ-021 In PUSH, gain_valid SHALL be 1 and the gains SHALL stay stable until gain_valid&&gain_ready; after transfer, the FSM goes to RAMP.
REQ-022 gain_valid SHALL never drop without a transfer.
REQ-023 A set_evt outside IDLE SHALL set pending (one-deep); further events are merged.
REQ-024 sample_tick outside RAMP SHALL be ignored, with no step accumulation.
REQ-025 Targets SHALL only change in CAPTURE; levels changing at other times have no effect.
REQ-026 Gain arithmetic SHALL be signed LEVEL_W with no wrap; clamping guarantees this.

Reset
REQ-027 On reset=0, asynchronously, the following SHALL clear to 0: all gains, targets, gain_valid, pending, the debounce counter, the synchronizer and the debounced level; state SHALL be IDLE and busy SHALL be 0.
REQ-028 Reset asserted mid-ramp or mid-PUSH SHALL abort immediately; no transfer is implied.

Configuration
REQ-029 With EQ_GAIN_RAMP_EN defined, ramping SHALL follow REQ-019 to REQ-021.
REQ-030 With EQ_GAIN_RAMP_EN undefined, CAPTURE SHALL load gains equal to the clamped targets and go directly to PUSH; after transfer it goes to IDLE.
REQ-031 With EQ_GAIN_RAMP_EN undefined, sample_tick SHALL be unused.

Structure
REQ-032 Package eq_ctrl_pkg SHALL hold the FSM state enum, the default LEVEL_W and the default clamp constants.
REQ-033 Sub-module set_debounce SHALL contain the synchronizer, debouncer and edge detector of REQ-014 and REQ-015.

Verification
REQ-034 Levels (3,-2,0), set pressed with DEBOUNCE_CYC=4, gain_ready=1, a tick every 10 cycles -> 3 transfers: (1,-1,0), (2,-2,0), (3,-2,0); then IDLE, busy=0.
REQ-035 Bass=15 -> target clamped to 12; 12 transfers observed; the final bass_gain is 12.
REQ-036 gain_ready held 0 for 50 cycles during PUSH -> gain_valid stays 1 with gains stable; ticks in that window cause no extra steps.
REQ-037 Second press mid-ramp with new levels (-4,0,0) -> pending set; after reaching the first target, a re-capture occurs and the ramp continues down to -4.
REQ-038 set glitch of 2 cycles with DEBOUNCE_CYC=4 -> no set_evt and busy stays 0.
REQ-039 Reset pulsed mid-ramp -> gains are 0 and gain_valid is 0 at once; with EQ_GAIN_RAMP_EN undefined, levels (5,5,5) give a single transfer of (5,5,5).
